// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: sync, per-channel glitch filter, priming FSM, Gray decode, error count.
// Build option QUAD_X4_EN selects x4 decode (step on every legal edge); default is x1 (one step per cycle).
module quad_step_decoder #(
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   output logic             step,
   output logic             upDown,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             ready
);

   localparam logic [3:0] FILT_LAST  = 4'(FILTER_LEN - 1);
   localparam logic [4:0] PRIME_LAST = 5'(FILTER_LEN + 2);

   typedef enum logic {
      PRIME,
      RUN
   } state_t;

   state_t           state_reg, state_next;
   logic [4:0]       prime_cnt_reg, prime_cnt_next;
   logic [1:0]       raw;
   logic [1:0]       q;
   logic [1:0]       p_reg;
   logic             priming;

   logic             step_reg, step_next;
   logic             updown_reg, updown_next;
   logic             err_reg, err_next;
   logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

   logic [1:0]       pos_diff;
   logic             is_up, is_dn, is_bad;
   logic             fire_up, fire_dn;

   assign raw     = {a_in, b_in};
   assign priming = (state_reg == PRIME);

   // Position of each {A,B} code along the forward (up) Gray sequence.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] pos;
      case (ab)
         2'b00:   pos = 2'd0;
         2'b10:   pos = 2'd1;
         2'b11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic       s1_reg, s2_reg;
         logic       q_bit_reg;
         logic [3:0] cnt_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_reg    <= 1'b0;
               s2_reg    <= 1'b0;
               q_bit_reg <= 1'b0;
               cnt_reg   <= 4'd0;
            end else begin
               s1_reg <= raw[gi];
               s2_reg <= s1_reg;
               if (priming) begin
                  q_bit_reg <= s2_reg;
                  cnt_reg   <= 4'd0;
               end else if (s2_reg != q_bit_reg) begin
                  if (cnt_reg == FILT_LAST) begin
                     q_bit_reg <= s2_reg;
                     cnt_reg   <= 4'd0;
                  end else begin
                     cnt_reg <= cnt_reg + 4'd1;
                  end
               end else begin
                  cnt_reg <= 4'd0;
               end
            end
         end

         assign q[gi] = q_bit_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= PRIME;
         prime_cnt_reg <= 5'd0;
      end else begin
         state_reg     <= state_next;
         prime_cnt_reg <= prime_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      prime_cnt_next = prime_cnt_reg;
      case (state_reg)
         PRIME: begin
            if (prime_cnt_reg == PRIME_LAST) begin
               state_next = RUN;
            end else begin
               prime_cnt_next = prime_cnt_reg + 5'd1;
            end
         end
         RUN:     state_next = RUN;
         default: state_next = PRIME;
      endcase
   end

   assign pos_diff = gray_pos(q) - gray_pos(p_reg);
   assign is_up    = (pos_diff == 2'd1);
   assign is_dn    = (pos_diff == 2'd3);
   assign is_bad   = (pos_diff == 2'd2);

`ifdef QUAD_X4_EN
   assign fire_up = is_up;
   assign fire_dn = is_dn;
`else
   // x1: count only the 01<->00 boundary of each full encoder cycle.
   assign fire_up = is_up && (p_reg == 2'b01);
   assign fire_dn = is_dn && (p_reg == 2'b00);
`endif

   always_comb begin
      step_next    = 1'b0;
      err_next     = 1'b0;
      updown_next  = updown_reg;
      err_cnt_next = err_cnt_reg;
      if (!priming) begin
         if (fire_up) begin
            step_next   = 1'b1;
            updown_next = 1'b1;
         end else if (fire_dn) begin
            step_next   = 1'b1;
            updown_next = 1'b0;
         end else if (is_bad) begin
            err_next = 1'b1;
            if (err_cnt_reg != {ERR_W{1'b1}}) begin
               err_cnt_next = err_cnt_reg + {{(ERR_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_reg       <= 2'b00;
         step_reg    <= 1'b0;
         updown_reg  <= 1'b1;
         err_reg     <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         p_reg       <= q;
         step_reg    <= step_next;
         updown_reg  <= updown_next;
         err_reg     <= err_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign step      = step_reg;
   assign upDown    = updown_reg;
   assign err       = err_reg;
   assign err_count = err_cnt_reg;
   assign ready     = (state_reg == RUN);

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage of the 4-bit up/down counter.
- Converts two asynchronous quadrature encoder lines (A, B) into a registered single-cycle count-enable pulse `step` plus a direction level `upDown`. The counter datapath consumes these.
- Contains input synchronisation, per-channel glitch filtering, a startup priming FSM, Gray-state decode, and illegal-transition detection with a saturating error count.

Parameters:
- FILTER_LEN, 4, consecutive cycles a synchronised channel must hold a new level before it is accepted; legal range 1..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  1  encoder channel A, asynchronous to clk.
- b_in  input  1  encoder channel B, asynchronous to clk.
- step  output  1  one-cycle count-enable pulse to the counter.
- upDown  output  1  direction: 1 = up (A leads B), 0 = down. Held between steps.
- err  output  1  one-cycle pulse on an illegal transition.
- err_count  output  ERR_W  saturating count of illegal transitions.
- ready  output  1  high once priming completes (FSM in RUN).

Behaviour:
- Reset (async assert; synchronous release edge handled by the flops):
  - step=0, upDown=1, err=0, err_count=0, ready=0.
  - Sync flops, filtered state `q`, previous state `p`, and filter counters all 0.
  - FSM enters PRIME.
- Synchronisation: each channel passes through 2 flops (s1, s2).
  - Edge E0 samples a new level into s1; s2 holds it after E1.
- Filter, per channel:
  - A counter increments on each edge where s2 != q_bit, and clears on any edge where they are equal.
  - On the edge where s2 != q_bit and counter == FILTER_LEN-1, the channel sets q_bit <= s2 and clears its counter.
  - Pulses shorter than FILTER_LEN cycles are rejected.
- FSM state PRIME:
  - q loads s2 directly, bypassing the filter; p <= q every cycle.
  - step and err are held 0.
  - A prime counter runs FILTER_LEN+3 cycles, then the FSM goes to RUN and ready=1.
- FSM state RUN:
  - Each edge: p <= q. Decode compares q (current) against p; outputs are registered.
  - Up transitions ({A,B}): 00→10, 10→11, 11→01, 01→00. Response: step=1, upDown<=1 next cycle.
  - Down transitions: the reverse of each up transition. Response: step=1, upDown<=0.
  - q == p: step=0, upDown holds.
  - Both bits differ (00↔11, 10↔01): err=1, step=0, upDown holds. err_count increments and saturates at all-ones. p still updates, so decoding resumes from the new state.
- Latency: a clean, stable level change sampled at E0 produces step high in the cycle following edge E(2+FILTER_LEN). Default: 6 cycles.
- step and err are never high in the same cycle. Each is high for at most one cycle per transition.
- Max legal input rate: one channel change per FILTER_LEN+1 cycles. Faster inputs may be filtered out or flagged as err. Both outcomes are acceptable.
- rst asserted mid-operation: all state clears immediately, any pending pulse is dropped, and the block re-primes. An edge in flight during PRIME produces no step.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined: x4 decode. Every legal transition produces a step, as above.
- Undefined: x1 decode, one step per full encoder cycle.
  - Up step only on 01→00.
  - Down step only on 00→01.
  - Other legal transitions update p but give step=0. upDown updates only when a step is issued.
  - Illegal-transition detection is identical in both modes.

Test Plan:
- Reset with a_in=b_in=1, release, hold → ready rises after FILTER_LEN+3 RUN-entry cycles (7 by default); no step or err at any point.
- x4, FILTER_LEN=4: drive {A,B} 00→10→11→01→00, each held 10 cycles → 4 step pulses, upDown=1; each pulse arrives 6 cycles after its input change.
- x4: reverse sequence 00→01→11→10→00 → 4 steps with upDown=0. Then stall at 00 for 20 cycles → no step; upDown stays 0.
- Glitch: a_in high for 3 cycles, FILTER_LEN=4 → no step, q unchanged. A 4-cycle pulse → one step up, then one step down on release.
- Illegal: a_in and b_in switch 00→11 on the same edge → one err pulse, err_count=1, no step, upDown unchanged. Repeat 300 times → err_count=255.
- x1 build (QUAD_X4_EN undefined): 3 full forward cycles → exactly 3 steps, upDown=1. Assert rst mid-cycle after 2 of them → outputs return to reset values at once and ready=0 until re-primed.
